videocard_top: RTL and testbench

VIDEOCARD_TOP -- requirements
Module: videocard_top

---
 rtl/videocard_top.sv | 158 +++++++++++++++
 tb/tb_videocard_top.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/videocard_top.sv
// Host-mapped data/instruction RAMs plus a small 16-register load/store core.
// The host loads RAMs and starts the core through a tiny control register file.
module videocard_top #(
    parameter int WIDTH       = 32,
    parameter int DATA_DEPTH  = 1024,
    parameter int INSTR_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               reset_sink_reset,
    input  logic [WIDTH/2:0]   address,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out,
    input  logic [WIDTH/8-1:0] byteenable,
    input  logic               write,
    input  logic               read,
    input  logic [2:0]         address_control,
    input  logic [WIDTH-1:0]   data_in_control,
    output logic [WIDTH-1:0]   data_out_control,
    input  logic               write_control,
    input  logic               read_control
);
    // Depths are powers of two, so "modulo depth" is just the low address bits.
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int IAW = $clog2(INSTR_DEPTH);
    localparam int NBE = WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM} state_e;
    localparam logic [3:0] OP_LDI = 4'h1, OP_LUI = 4'h2, OP_LD = 4'h3, OP_ST = 4'h4,
                           OP_ADD = 4'h5, OP_SUB = 4'h6, OP_ADDI = 4'h7, OP_BNZ = 4'h8,
                           OP_JMP = 4'h9, OP_HALT = 4'hF;

    logic [WIDTH-1:0] dmem [DATA_DEPTH];
    logic [WIDTH-1:0] imem [INSTR_DEPTH];

    state_e                 state_q, state_d;
    logic [IAW-1:0]         pc_q, pc_d;
    logic [15:0][WIDTH-1:0] regs_q;
    logic                   done_q;
    logic [WIDTH-1:0]       ir_q, ld_q, data_out_q;

    logic             busy, start, fetch_en, exec_en, mem_en;
    logic             wb_en, st_en;
    logic [WIDTH-1:0] wb_val, rd_v, rs_v, sext, zext, addr_sum;
    logic [3:0]       op, rd, rs;
    logic [15:0]      imm;
    logic [DAW-1:0]   maddr, h_daddr;
    logic [IAW-1:0]   h_iaddr;
    logic             sel_imem;

    assign sel_imem = address[WIDTH/2];
    assign h_daddr  = address[DAW-1:0];
    assign h_iaddr  = address[IAW-1:0];
    assign busy     = (state_q != S_IDLE);
    assign start    = write_control && (address_control == 3'd0) && data_in_control[0] && !busy;

    assign op   = ir_q[31:28];
    assign rd   = ir_q[27:24];
    assign rs   = ir_q[23:20];
    assign imm  = ir_q[15:0];
    assign rd_v = regs_q[rd];
    assign rs_v = regs_q[rs];
    assign sext = {{(WIDTH-16){imm[15]}}, imm};
    assign zext = {{(WIDTH-16){1'b0}}, imm};
    assign addr_sum = rs_v + sext;
    assign maddr    = addr_sum[DAW-1:0];

    always_ff @(posedge clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) state_q <= S_IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = (op == OP_LD) ? S_MEM : (op == OP_HALT) ? S_IDLE : S_FETCH;
            S_MEM:   state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_en = (state_q == S_FETCH);
        exec_en  = (state_q == S_EXEC);
        mem_en   = (state_q == S_MEM);
    end

    // Execute datapath: register writeback, store strobe and next PC.
    always_comb begin
        wb_en  = 1'b0;
        wb_val = rd_v;
        st_en  = 1'b0;
        pc_d   = pc_q + IAW'(1);
        if (exec_en) begin
            case (op)
                OP_LDI:  begin wb_en = 1'b1; wb_val = zext; end
                OP_LUI:  begin wb_en = 1'b1; wb_val[WIDTH-1 -: 16] = imm; end
                OP_ST:   st_en = 1'b1;
                OP_ADD:  begin wb_en = 1'b1; wb_val = rd_v + rs_v; end
                OP_SUB:  begin wb_en = 1'b1; wb_val = rd_v - rs_v; end
                OP_ADDI: begin wb_en = 1'b1; wb_val = rd_v + sext; end
                OP_BNZ:  if (rd_v != '0) pc_d = imm[IAW-1:0];
                OP_JMP:  pc_d = imm[IAW-1:0];
                default: ;
            endcase
        end else if (mem_en) begin
            wb_en  = 1'b1;
            wb_val = ld_q;
        end
    end

    always_ff @(posedge clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            pc_q       <= '0;
            regs_q     <= '0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            if (start) begin
                pc_q   <= '0;
                done_q <= 1'b0;
            end else if (exec_en) begin
                pc_q <= pc_d;
                if (op == OP_HALT) done_q <= 1'b1;
            end
            if (wb_en) regs_q[rd] <= wb_val;
            if (read) data_out_q <= sel_imem ? imem[h_iaddr] : dmem[h_daddr];
        end
    end

    // Host byte writes come after the core store so the host wins a same-word collision.
    always_ff @(posedge clk) begin
        if (fetch_en) ir_q <= imem[pc_q];
        if (exec_en && op == OP_LD) ld_q <= dmem[maddr];
        if (st_en) dmem[maddr] <= rd_v;
        if (write && !sel_imem)
            for (int b = 0; b < NBE; b++)
                if (byteenable[b]) dmem[h_daddr][b*8 +: 8] <= data_in[b*8 +: 8];
        if (write && sel_imem && !busy)
            for (int b = 0; b < NBE; b++)
                if (byteenable[b]) imem[h_iaddr][b*8 +: 8] <= data_in[b*8 +: 8];
    end

    always_comb begin
        data_out_control = '0;
        if (read_control) begin
            case (address_control)
                3'd1:    data_out_control = {{(WIDTH-2){1'b0}}, done_q, busy};
                3'd2:    data_out_control = WIDTH'(pc_q);
                default: data_out_control = '0;
            endcase
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_videocard_top.sv
// Directed bench for videocard_top: host RAM access, control registers and core programs.
module tb_videocard_top;
    logic        clk = 1'b0;
    logic        reset_sink_reset = 1'b1;
    logic [16:0] address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic [3:0]  byteenable = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [2:0]  address_control = '0;
    logic [31:0] data_in_control = '0;
    logic [31:0] data_out_control;
    logic        write_control = 1'b0;
    logic        read_control = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    videocard_top dut (
        .clk(clk), .reset_sink_reset(reset_sink_reset),
        .address(address), .data_in(data_in), .data_out(data_out),
        .byteenable(byteenable), .write(write), .read(read),
        .address_control(address_control), .data_in_control(data_in_control),
        .data_out_control(data_out_control), .write_control(write_control),
        .read_control(read_control)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic host_wr(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; data_in = d; byteenable = be; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic host_rd(input logic [16:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        d = data_out;
    endtask

    task automatic ctrl_wr(input logic [2:0] idx, input logic [31:0] d);
        address_control = idx; data_in_control = d; write_control = 1'b1;
        tick();
        write_control = 1'b0;
    endtask

    task automatic ctrl_rd(input logic [2:0] idx, output logic [31:0] d);
        address_control = idx; read_control = 1'b1;
        #1 d = data_out_control;
        read_control = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic [31:0] s;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            ctrl_rd(3'd1, s);
            if (s[1]) begin ok = 1'b1; break; end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    logic [31:0] vsum_prog [10] = '{
        32'h1100_0000, 32'h1200_000F, 32'h1300_0000, 32'h3410_0000, 32'h5340_0000,
        32'h7100_0001, 32'h7200_FFFF, 32'h8200_0003, 32'h4300_000F, 32'hF000_0000 };
    logic [31:0] vsum_data [15] = '{2, 12, 3, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    logic [31:0] misc_prog [11] = '{
        32'h1500_1234, 32'h2500_ABCD, 32'h1600_0235, 32'h6560_0000, 32'h9000_0006,
        32'h1500_0000, 32'h4500_0014, 32'h1700_0000, 32'h7700_FFFF, 32'h4700_FFFF,
        32'hF000_0000 };

    initial begin
        logic [31:0] r;

        // Reset state
        repeat (2) tick();
        ctrl_rd(3'd1, r); chk("rst_status", r, 32'h0);
        ctrl_rd(3'd2, r); chk("rst_pc", r, 32'h0);
        chk("rst_dout", data_out, 32'h0);
        ctrl_rd(3'd5, r); chk("reg5_zero", r, 32'h0);
        reset_sink_reset = 1'b0;
        tick();

        // Byte enables
        host_wr(17'h00003, 32'h0, 4'hF);
        host_wr(17'h00003, 32'hDEADBEEF, 4'b0011);
        host_rd(17'h00003, r); chk("be_low_half", r, 32'h0000BEEF);
        address = 17'h00000;
        tick();
        chk("dout_hold", data_out, 32'h0000BEEF);

        // Immediate halt: busy for exactly two cycles
        host_wr(17'h10000, 32'hF000_0000, 4'hF);
        ctrl_wr(3'd0, 32'h1);
        ctrl_rd(3'd1, r); chk("halt_busy_c1", r, 32'h1);
        tick();
        ctrl_rd(3'd1, r); chk("halt_busy_c2", r, 32'h1);
        tick();
        ctrl_rd(3'd1, r); chk("halt_status", r, 32'h2);
        ctrl_rd(3'd2, r); chk("halt_pc", r, 32'h1);

        // Vector sum, with a second start and an imem write attempted mid-run
        for (int i = 0; i < 10; i++) host_wr(17'h10000 | 17'(i), vsum_prog[i], 4'hF);
        for (int i = 0; i < 15; i++) host_wr(17'(i), vsum_data[i], 4'hF);
        host_wr(17'h0000F, 32'h0, 4'hF);
        ctrl_wr(3'd0, 32'h1);
        ctrl_rd(3'd1, r); chk("vsum_busy", r, 32'h1);
        tick();
        ctrl_wr(3'd0, 32'h1);
        host_wr(17'h10009, 32'h0, 4'hF);
        wait_done("vsum_done", 1000);
        ctrl_rd(3'd1, r); chk("vsum_status", r, 32'h2);
        ctrl_rd(3'd2, r); chk("vsum_pc", r, 32'd10);
        host_rd(17'h0000F, r); chk("vsum_result", r, 32'h5F);
        host_rd(17'h10009, r); chk("imem_protect", r, 32'hF000_0000);

        // Reset mid-run aborts without further stores
        host_wr(17'h0000F, 32'h1234, 4'hF);
        ctrl_wr(3'd0, 32'h1);
        repeat (40) tick();
        reset_sink_reset = 1'b1;
        ctrl_rd(3'd1, r); chk("midrst_status", r, 32'h0);
        ctrl_rd(3'd2, r); chk("midrst_pc", r, 32'h0);
        tick();
        reset_sink_reset = 1'b0;
        repeat (250) tick();
        host_rd(17'h0000F, r); chk("midrst_word15", r, 32'h1234);

        // LUI/SUB/JMP, negative offsets and host address wraparound
        for (int i = 0; i < 11; i++) host_wr(17'h10000 | 17'(i), misc_prog[i], 4'hF);
        ctrl_wr(3'd0, 32'h1);
        wait_done("misc_done", 200);
        ctrl_rd(3'd2, r); chk("misc_pc", r, 32'd11);
        host_rd(17'h00414, r); chk("misc_lui_sub", r, 32'hABCD_0FFF);
        host_rd(17'h003FF, r); chk("misc_neg_addr", r, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
